// File: rtl/cam_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl_if
//   Bundles the control, camera-timing and status signals of the camera
//   capture sequencer.
//
//   Parameters
//     V_LINES  lines per frame (sets the width of line_cnt)
//     FCW      width of frame_cnt
//
//   Signals
//     start, stop, continuous     control requests from the top-level logic
//     VSYNC, HREF                 camera timing, already synchronised to CLK
//     px_wr                       one pulse per pixel stored by the writer
//     capture_en, frame_start     writer gating / address clear
//     busy, done, err             status
//     line_cnt, frame_cnt         line and frame counters
//
//   Modports
//     master  drives the requests and camera timing, observes status
//     slave   the capture sequencer itself
// ---------------------------------------------------------------------------
interface cam_capture_ctrl_if #(
    parameter int V_LINES = 120,
    parameter int FCW     = 8
);
    localparam int LW = $clog2(V_LINES + 1);

    logic           start;
    logic           stop;
    logic           continuous;
    logic           VSYNC;
    logic           HREF;
    logic           px_wr;
    logic           capture_en;
    logic           frame_start;
    logic           busy;
    logic           done;
    logic [2:0]     err;
    logic [LW-1:0]  line_cnt;
    logic [FCW-1:0] frame_cnt;

    modport master (
        output start, stop, continuous, VSYNC, HREF, px_wr,
        input  capture_en, frame_start, busy, done, err, line_cnt, frame_cnt
    );

    modport slave (
        input  start, stop, continuous, VSYNC, HREF, px_wr,
        output capture_en, frame_start, busy, done, err, line_cnt, frame_cnt
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cam_capture_ctrl
//   Sequences the camera pixel-capture path. A start request arms the block.
//   Capture then waits for a complete VSYNC pulse, so the frame is always
//   taken from its beginning. While capturing, pixels per line and lines per
//   frame are checked against the expected geometry. The block reports done
//   and sticky error status. It can re-arm every frame in continuous mode.
//
//   Ports
//     CLK   system clock, all logic on its rising edge
//     rst   asynchronous, active-high reset
//     bus   cam_capture_ctrl_if.slave
//           inputs  : start, stop, continuous, VSYNC, HREF, px_wr
//           outputs : capture_en, frame_start, busy, done,
//                     err[2:0], line_cnt, frame_cnt
//
//   err bits (sticky, cleared by an accepted start)
//     [0] a line carried a pixel count other than H_PIXELS
//     [1] a frame carried a line count other than V_LINES
//     [2] the capture was aborted by stop in the middle of a frame
//
//   Optional feature macro: CAPTURE_FRAME_CNT_EN
//     defined     : frame_cnt counts done pulses, wraps, cleared only by rst
//     not defined : frame_cnt is tied to zero
// ---------------------------------------------------------------------------
module cam_capture_ctrl #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 120,
    parameter int FCW      = 8
) (
    input logic               CLK,
    input logic               rst,
    cam_capture_ctrl_if.slave bus
);
    localparam int LW = $clog2(V_LINES + 1);
    localparam int PW = $clog2(H_PIXELS + 1);
    localparam logic [LW-1:0] LINES_EXP  = LW'(V_LINES);
    localparam logic [PW-1:0] PIXELS_EXP = PW'(H_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        state_reg;
    logic          vs_q_reg;
    logic          hr_q_reg;
    logic          cont_reg;
    logic          capture_en_reg;
    logic          frame_start_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [2:0]    err_reg;
    logic [LW-1:0] line_cnt_reg;
    logic [PW-1:0] px_cnt_reg;

    logic          vs_rise;
    logic          vs_fall;
    logic          hr_rise;
    logic          hr_fall;
    logic [LW-1:0] line_cnt_inc;
    logic [LW-1:0] line_cnt_next;

    assign vs_rise = bus.VSYNC & ~vs_q_reg;
    assign vs_fall = ~bus.VSYNC & vs_q_reg;
    assign hr_rise = bus.HREF & ~hr_q_reg;
    assign hr_fall = ~bus.HREF & hr_q_reg;

    // Saturating line increment. line_cnt_next also covers a line that ends
    // in the same cycle as the frame, so the end-of-frame check sees it.
    assign line_cnt_inc  = (&line_cnt_reg) ? line_cnt_reg : line_cnt_reg + LW'(1);
    assign line_cnt_next = hr_fall ? line_cnt_inc : line_cnt_reg;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            vs_q_reg        <= 1'b0;
            hr_q_reg        <= 1'b0;
            cont_reg        <= 1'b0;
            capture_en_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 3'b000;
            line_cnt_reg    <= '0;
            px_cnt_reg      <= '0;
        end else begin
            vs_q_reg        <= bus.VSYNC;
            hr_q_reg        <= bus.HREF;
            frame_start_reg <= 1'b0;
            done_reg        <= 1'b0;

            if (bus.stop && (state_reg != S_IDLE)) begin
                // Abort from any active state. Only a capture in progress
                // counts as an aborted frame.
                state_reg      <= S_IDLE;
                busy_reg       <= 1'b0;
                capture_en_reg <= 1'b0;
                if (state_reg == S_CAPTURE) begin
                    err_reg[2] <= 1'b1;
                end
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        // A stop in the same cycle suppresses the start.
                        if (bus.start && !bus.stop) begin
                            state_reg <= S_ARM;
                            busy_reg  <= 1'b1;
                            err_reg   <= 3'b000;
                            cont_reg  <= bus.continuous;
                        end
                    end
                    S_ARM: begin
                        // Skip the rest of any frame already in flight.
                        if (vs_rise) begin
                            state_reg <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (vs_fall) begin
                            state_reg       <= S_CAPTURE;
                            frame_start_reg <= 1'b1;
                            line_cnt_reg    <= '0;
                            px_cnt_reg      <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        capture_en_reg <= 1'b1;
                        if (hr_rise) begin
                            px_cnt_reg <= bus.px_wr ? PW'(1) : '0;
                        end else if (bus.px_wr && bus.HREF && !(&px_cnt_reg)) begin
                            px_cnt_reg <= px_cnt_reg + PW'(1);
                        end
                        if (hr_fall) begin
                            line_cnt_reg <= line_cnt_inc;
                            if (px_cnt_reg != PIXELS_EXP) begin
                                err_reg[0] <= 1'b1;
                            end
                        end
                        if (vs_rise) begin
                            capture_en_reg <= 1'b0;
                            done_reg       <= 1'b1;
                            if (line_cnt_next != LINES_EXP) begin
                                err_reg[1] <= 1'b1;
                            end
                            state_reg <= cont_reg ? S_SYNC : S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg      <= S_IDLE;
                        busy_reg       <= 1'b0;
                        capture_en_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.capture_en  = capture_en_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.err         = err_reg;
    assign bus.line_cnt    = line_cnt_reg;

`ifdef CAPTURE_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt_reg;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (done_reg) begin
            frame_cnt_reg <= frame_cnt_reg + FCW'(1);
        end
    end

    assign bus.frame_cnt = frame_cnt_reg;
`else
    assign bus.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_capture_ctrl
//   Drives randomised camera timing into cam_capture_ctrl. The geometry is
//   reduced to H x V so that many frames fit in a short run. Expected status
//   is derived from frame descriptions: lines per frame and which line is
//   malformed.
// ---------------------------------------------------------------------------
module tb_cam_capture_ctrl;
    localparam int H   = 20;
    localparam int V   = 12;
    localparam int FCW = 8;
    localparam int LW  = $clog2(V + 1);

    logic CLK = 1'b0;
    logic rst = 1'b1;

    always #5 CLK = ~CLK;

    cam_capture_ctrl_if #(.V_LINES(V), .FCW(FCW)) bus ();

    cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .FCW(FCW)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int checks       = 0;
    int passed       = 0;
    int done_cnt     = 0;
    int fs_cnt       = 0;
    int cap_cycles   = 0;
    int frames_model = 0;   // frames completed since the last reset

    // Pulse and activity counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (bus.done === 1'b1)        done_cnt++;
        if (bus.frame_start === 1'b1) fs_cnt++;
        if (bus.capture_en === 1'b1)  cap_cycles++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------ model
    function automatic logic [2:0] model_err(input int nlines, input int bad_line,
                                             input int bad_px, input logic aborted);
        logic [2:0] e;
        e[0] = (bad_line >= 0) && (bad_line < nlines) && (bad_px != H);
        e[1] = (nlines != V);
        e[2] = aborted;
        return e;
    endfunction

    function automatic logic [FCW-1:0] model_frame_cnt();
`ifdef CAPTURE_FRAME_CNT_EN
        return FCW'(frames_model);
`else
        return '0;
`endif
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic cont);
        bus.start      = 1'b1;
        bus.continuous = cont;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic send_line(input int npx);
        bus.HREF = 1'b1;
        tick();
        for (int i = 0; i < npx; i++) begin
            bus.px_wr = 1'b1;
            tick();
            bus.px_wr = 1'b0;
            if ($urandom_range(0, 1) == 1) tick();
        end
        bus.HREF = 1'b0;
        tick();
        repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic send_lines(input int nlines, input int bad_line, input int bad_px);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == bad_line) ? bad_px : H);
        end
    endtask

    // Full VSYNC pulse; reports done and capture_en one cycle after its rise.
    task automatic vsync_pulse(output logic done_seen, output logic cap_seen);
        bus.VSYNC = 1'b1;
        tick();
        done_seen = bus.done;
        cap_seen  = bus.capture_en;
        tick();
        tick();
        bus.VSYNC = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic run_single(input int nlines, input int bad_line, input int bad_px,
                              output logic done_seen, output logic cap_seen);
        logic d0, c0;
        pulse_start(1'b0);
        vsync_pulse(d0, c0);
        send_lines(nlines, bad_line, bad_px);
        vsync_pulse(done_seen, cap_seen);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if ({bus.busy, bus.capture_en, bus.done, bus.frame_start} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.capture_en, bus.done, bus.frame_start}); else passed++;
        checks++; if (bus.err !== 3'b000)
            $display("FAIL reset_err: got %b expected 000", bus.err); else passed++;
        checks++; if ({bus.line_cnt, bus.frame_cnt} !== '0)
            $display("FAIL reset_counts: got line %0d frame %0d expected 0 0", bus.line_cnt, bus.frame_cnt); else passed++;
        rst = 1'b0;
        frames_model = 0;
        tick();
        checks++; if (bus.busy !== 1'b0)
            $display("FAIL reset_release_busy: got %b expected 0", bus.busy); else passed++;
        $display("reset: released");
    endtask

    task automatic test_single_shot();
        logic d, c;
        int   d0, f0;
        d0 = done_cnt;
        f0 = fs_cnt;
        run_single(V, -1, H, d, c);
        frames_model++;
        $display("single_shot: lines=%0d err=%b line_cnt=%0d", V, bus.err, bus.line_cnt);
        checks++; if (d !== 1'b1)
            $display("FAIL single_done_timing: got %b expected 1", d); else passed++;
        checks++; if (c !== 1'b0)
            $display("FAIL single_cap_off: got %b expected 0", c); else passed++;
        checks++; if (done_cnt - d0 !== 1)
            $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); else passed++;
        checks++; if (fs_cnt - f0 !== 1)
            $display("FAIL single_fs_count: got %0d expected 1", fs_cnt - f0); else passed++;
        checks++; if (bus.err !== 3'b000)
            $display("FAIL single_err: got %b expected 000", bus.err); else passed++;
        checks++; if (bus.line_cnt !== LW'(V))
            $display("FAIL single_line_cnt: got %0d expected %0d", bus.line_cnt, V); else passed++;
        checks++; if (bus.busy !== 1'b0)
            $display("FAIL single_busy: got %b expected 0", bus.busy); else passed++;
        checks++; if (bus.frame_cnt !== model_frame_cnt())
            $display("FAIL single_frame_cnt: got %0d expected %0d", bus.frame_cnt, model_frame_cnt()); else passed++;
    endtask

    task automatic test_start_mid_frame();
        logic d, c;
        int   c0, f0;
        c0 = cap_cycles;
        f0 = fs_cnt;
        vsync_pulse(d, c);
        send_lines(4, -1, H);
        pulse_start(1'b0);
        send_lines(V - 4, -1, H);
        checks++; if (cap_cycles - c0 !== 0)
            $display("FAIL midframe_cap_partial: got %0d enabled cycles expected 0", cap_cycles - c0); else passed++;
        checks++; if ((fs_cnt - f0 !== 0) || (bus.busy !== 1'b1))
            $display("FAIL midframe_armed: got fs %0d busy %b expected fs 0 busy 1", fs_cnt - f0, bus.busy); else passed++;
        vsync_pulse(d, c);
        checks++; if (d !== 1'b0)
            $display("FAIL midframe_no_done: got %b expected 0", d); else passed++;
        checks++; if ((fs_cnt - f0 !== 1) || (bus.capture_en !== 1'b1))
            $display("FAIL midframe_capture: got fs %0d cap %b expected fs 1 cap 1", fs_cnt - f0, bus.capture_en); else passed++;
        send_lines(V, -1, H);
        vsync_pulse(d, c);
        frames_model++;
        $display("start_mid_frame: err=%b line_cnt=%0d", bus.err, bus.line_cnt);
        checks++; if ((d !== 1'b1) || (bus.err !== 3'b000) || (bus.line_cnt !== LW'(V)))
            $display("FAIL midframe_result: got done %b err %b lines %0d expected 1 000 %0d", d, bus.err, bus.line_cnt, V); else passed++;
    endtask

    task automatic test_short_line();
        logic d, c, d0, c0;
        pulse_start(1'b0);
        vsync_pulse(d0, c0);
        send_lines(V, 5, H - 1);
        pulse_start(1'b1);              // ignored: already busy
        vsync_pulse(d, c);
        frames_model++;
        $display("short_line: err=%b line_cnt=%0d busy=%b", bus.err, bus.line_cnt, bus.busy);
        checks++; if (d !== 1'b1)
            $display("FAIL short_done: got %b expected 1", d); else passed++;
        checks++; if (bus.err !== model_err(V, 5, H - 1, 1'b0))
            $display("FAIL short_err: got %b expected %b", bus.err, model_err(V, 5, H - 1, 1'b0)); else passed++;
        checks++; if (bus.busy !== 1'b0)
            $display("FAIL short_start_ignored: got busy %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_missing_lines();
        logic d, c;
        run_single(V - 2, -1, H, d, c);
        frames_model++;
        $display("missing_lines: err=%b line_cnt=%0d", bus.err, bus.line_cnt);
        checks++; if (bus.err !== model_err(V - 2, -1, H, 1'b0))
            $display("FAIL missing_err: got %b expected %b", bus.err, model_err(V - 2, -1, H, 1'b0)); else passed++;
        checks++; if (bus.line_cnt !== LW'(V - 2))
            $display("FAIL missing_line_cnt: got %0d expected %0d", bus.line_cnt, V - 2); else passed++;
        checks++; if (d !== 1'b1)
            $display("FAIL missing_done: got %b expected 1", d); else passed++;
    endtask

    task automatic test_start_stop_same();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tick();
        $display("start_stop_same: busy=%b", bus.busy);
        checks++; if (bus.busy !== 1'b0)
            $display("FAIL start_stop_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_random_frames();
        logic       d, c;
        int         nlines, bad_line, bad_px;
        logic [2:0] exp_err;
        for (int n = 0; n < 5; n++) begin
            nlines   = V - 2 + int'($urandom_range(0, 4));
            bad_line = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nlines - 1)) : -1;
            bad_px   = ($urandom_range(0, 1) == 1) ? H + 1 : H - 1;
            exp_err  = model_err(nlines, bad_line, bad_px, 1'b0);
            run_single(nlines, bad_line, bad_px, d, c);
            frames_model++;
            $display("random frame %0d: lines=%0d bad_line=%0d bad_px=%0d err=%b", n, nlines, bad_line, bad_px, bus.err);
            checks++; if ((d !== 1'b1) || (c !== 1'b0))
                $display("FAIL random_done_%0d: got done %b cap %b expected 1 0", n, d, c); else passed++;
            checks++; if (bus.err !== exp_err)
                $display("FAIL random_err_%0d: got %b expected %b", n, bus.err, exp_err); else passed++;
            checks++; if (bus.line_cnt !== LW'(nlines))
                $display("FAIL random_lines_%0d: got %0d expected %0d", n, bus.line_cnt, nlines); else passed++;
            checks++; if (bus.frame_cnt !== model_frame_cnt())
                $display("FAIL random_frame_cnt_%0d: got %0d expected %0d", n, bus.frame_cnt, model_frame_cnt()); else passed++;
        end
    endtask

    task automatic test_continuous_stop();
        logic d, c;
        int   d0, f0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frames_model = 0;
        d0 = done_cnt;
        f0 = fs_cnt;
        pulse_start(1'b1);
        vsync_pulse(d, c);
        for (int f = 0; f < 3; f++) begin
            send_lines(V, -1, H);
            vsync_pulse(d, c);
            frames_model++;
            $display("continuous frame %0d: done=%b err=%b", f, d, bus.err);
            checks++; if ((d !== 1'b1) || (bus.err !== 3'b000))
                $display("FAIL cont_frame_%0d: got done %b err %b expected 1 000", f, d, bus.err); else passed++;
        end
        send_lines(3, -1, H);
        bus.HREF = 1'b1;
        tick();
        checks++; if (bus.capture_en !== 1'b1)
            $display("FAIL cont_cap_before_stop: got %b expected 1", bus.capture_en); else passed++;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++; if ((bus.capture_en !== 1'b0) || (bus.busy !== 1'b0))
            $display("FAIL cont_stop_response: got cap %b busy %b expected 0 0", bus.capture_en, bus.busy); else passed++;
        bus.HREF = 1'b0;
        tick();
        tick();
        $display("continuous stop: done=%0d fs=%0d err=%b frame_cnt=%0d", done_cnt - d0, fs_cnt - f0, bus.err, bus.frame_cnt);
        checks++; if (bus.err !== model_err(V, -1, H, 1'b1))
            $display("FAIL cont_err: got %b expected %b", bus.err, model_err(V, -1, H, 1'b1)); else passed++;
        checks++; if (done_cnt - d0 !== 3)
            $display("FAIL cont_done_count: got %0d expected 3", done_cnt - d0); else passed++;
        checks++; if (fs_cnt - f0 !== 4)
            $display("FAIL cont_fs_count: got %0d expected 4", fs_cnt - f0); else passed++;
        checks++; if (bus.frame_cnt !== model_frame_cnt())
            $display("FAIL cont_frame_cnt: got %0d expected %0d", bus.frame_cnt, model_frame_cnt()); else passed++;
    endtask

    task automatic test_rst_mid_capture();
        logic d, c;
        pulse_start(1'b0);
        vsync_pulse(d, c);
        send_lines(4, -1, H);
        bus.HREF = 1'b1;
        tick();
        repeat (3) begin
            bus.px_wr = 1'b1;
            tick();
            bus.px_wr = 1'b0;
        end
        checks++; if ((bus.line_cnt !== LW'(4)) || (bus.capture_en !== 1'b1))
            $display("FAIL rst_pre_state: got lines %0d cap %b expected 4 1", bus.line_cnt, bus.capture_en); else passed++;
        rst = 1'b1;
        #2;
        checks++; if ({bus.busy, bus.capture_en, bus.done, bus.frame_start} !== 4'b0000)
            $display("FAIL rst_async_flags: got %b expected 0000", {bus.busy, bus.capture_en, bus.done, bus.frame_start}); else passed++;
        checks++; if ({bus.err, bus.line_cnt, bus.frame_cnt} !== '0)
            $display("FAIL rst_async_status: got err %b lines %0d frames %0d expected 0 0 0", bus.err, bus.line_cnt, bus.frame_cnt); else passed++;
        bus.HREF = 1'b0;
        tick();
        rst = 1'b0;
        frames_model = 0;
        tick();
        run_single(V, -1, H, d, c);
        frames_model++;
        $display("rst_mid_capture: recapture err=%b line_cnt=%0d", bus.err, bus.line_cnt);
        checks++; if ((d !== 1'b1) || (bus.err !== 3'b000) || (bus.line_cnt !== LW'(V)))
            $display("FAIL rst_recapture: got done %b err %b lines %0d expected 1 000 %0d", d, bus.err, bus.line_cnt, V); else passed++;
        checks++; if (bus.frame_cnt !== model_frame_cnt())
            $display("FAIL rst_frame_cnt: got %0d expected %0d", bus.frame_cnt, model_frame_cnt()); else passed++;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.continuous = 1'b0;
        bus.VSYNC      = 1'b0;
        bus.HREF       = 1'b0;
        bus.px_wr      = 1'b0;
        test_reset();
        test_single_shot();
        test_start_mid_frame();
        test_short_line();
        test_missing_lines();
        test_start_stop_same();
        test_random_frames();
        test_continuous_stop();
        test_rst_mid_capture();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
